hazard_control_unit: RTL and testbench

Pipeline sequencer for the 5-stage datapath. Drives the Write/clear controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazards:
- load-use data hazards (stall plus bubble),
- taken branches resolved in MEM (flush),
- multi-cycle data-memory accesses (whole-pipeline freeze).

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/load_use_detector.sv | 32 +++
 rtl/hazard_control_unit.sv | 162 ++++++++++++++++
 tb/tb_hazard_control_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared constants for the pipeline hazard control slice
//
// Holds the FSM state encoding, the default register-address width, the
// zero-register constant and a helper sizing the memory-wait counter.

package pipeline_ctrl_pkg;

  localparam logic [0:0] STATE_RUN      = 1'b0;
  localparam logic [0:0] STATE_MEM_WAIT = 1'b1;

  localparam int DEFAULT_REG_ADDR_W = 5;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a hazard.
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Width of a down-counter able to hold 'latency', never narrower than 1 bit.
  function automatic int cnt_width(input int latency);
    int w;
    w = $clog2(latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// rtl/load_use_detector.sv - combinational load-use hazard comparator
//
// Ports:
//   mem_read  : instruction in EX is a load
//   ex_rt     : load destination register in EX
//   id_rs     : source register 1 of instruction in ID
//   id_rt     : source register 2 of instruction in ID
//   hit       : ID instruction consumes the result of the load in EX

module load_use_detector
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hit
);

  logic targets_zero;
  logic rs_match;
  logic rt_match;

  assign targets_zero = (ex_rt == REG_ADDR_W'(ZERO_REG));
  assign rs_match     = (ex_rt == id_rs);
  assign rt_match     = (ex_rt == id_rt);

  assign hit = mem_read && !targets_zero && (rs_match || rt_match);

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - 5-stage pipeline sequencer (stall, flush, memory freeze)
//
// Optional feature macro: HAZARD_STATS_EN (adds Stall_Count / Flush_Count).
//
// Ports:
//   clock, reset             : pipeline clock (rising edge), async active-high reset
//   ID_EX_MemRead, ID_EX_Rt  : load in EX and its destination register
//   IF_ID_Rs, IF_ID_Rt       : source registers of the instruction in ID
//   Branch_Taken             : branch resolved taken in MEM
//   Mem_Access               : instruction in MEM is a load/store
//   PC_Write, *_Write        : PC and pipeline-register load enables
//   IF_ID/ID_EX/EX_MEM_clear : synchronous bubble-insertion clears
//   Stall                    : PC is held this cycle
//   Stall_Count, Flush_Count : (HAZARD_STATS_EN only) wrapping event counters

module hazard_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rt,
  input  logic                  Branch_Taken,
  input  logic                  Mem_Access,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  EX_MEM_Write,
  output logic                  MEM_WB_Write,
  output logic                  IF_ID_clear,
  output logic                  ID_EX_clear,
  output logic                  EX_MEM_clear,
  output logic                  Stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           Stall_Count,
  output logic [31:0]           Flush_Count
`endif
);

  localparam int CNT_W = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  logic [0:0]       state;
  // In MEM_WAIT this holds the number of frozen cycles still to come,
  // counting the current one, so the access costs MEM_LATENCY cycles in total.
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_served;
  logic             load_use_hit;
  logic             freeze_req;
  logic             in_run;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detector (
    .mem_read (ID_EX_MemRead),
    .ex_rt    (ID_EX_Rt),
    .id_rs    (IF_ID_Rs),
    .id_rt    (IF_ID_Rt),
    .hit      (load_use_hit)
  );

  assign in_run     = (state == STATE_RUN);
  // mem_served stops the same access from freezing again once its wait is over.
  assign freeze_req = (MEM_LATENCY > 0) && Mem_Access && !mem_served;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    IF_ID_clear  = 1'b0;
    ID_EX_clear  = 1'b0;
    EX_MEM_clear = 1'b0;

    if (reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
      IF_ID_clear  = 1'b1;
      ID_EX_clear  = 1'b1;
      EX_MEM_clear = 1'b1;
    end else if (!in_run) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (Branch_Taken) begin
      // Discard the three wrong-path instructions behind the branch at once.
      IF_ID_clear  = 1'b1;
      ID_EX_clear  = 1'b1;
      EX_MEM_clear = 1'b1;
    end else if (freeze_req) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (load_use_hit) begin
      // Hold PC and IF/ID, inject one bubble into EX; older stages drain.
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_clear  = 1'b1;
    end

    Stall = !reset && !PC_Write;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= STATE_RUN;
      wait_cnt   <= '0;
      mem_served <= 1'b0;
    end else if (in_run) begin
      if (EX_MEM_Write) begin
        mem_served <= 1'b0;
      end
      if (!Branch_Taken && freeze_req) begin
        if (MEM_LATENCY == 1) begin
          mem_served <= 1'b1;
        end else begin
          state    <= STATE_MEM_WAIT;
          wait_cnt <= WAIT_INIT;
        end
      end
    end else begin
      if (wait_cnt <= CNT_W'(1)) begin
        state      <= STATE_RUN;
        wait_cnt   <= '0;
        mem_served <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (Stall) begin
        Stall_Count <= Stall_Count + 32'd1;
      end
      if (in_run && Branch_Taken) begin
        Flush_Count <= Flush_Count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit

module tb_hazard_control_unit;

  // Vector order: PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, EX_MEM clears, Stall
  localparam logic [8:0] V_RESET = 9'b00000_111_0;
  localparam logic [8:0] V_IDLE  = 9'b11111_000_0;
  localparam logic [8:0] V_FLUSH = 9'b11111_111_0;
  localparam logic [8:0] V_FRZ   = 9'b00000_000_1;
  localparam logic [8:0] V_LU    = 9'b00111_010_1;

  logic       clock;
  logic       reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       Branch_Taken;
  logic       Mem_Access;

  logic a_pc, a_ifw, a_idw, a_exw, a_wbw, a_ifc, a_idc, a_exc, a_st;
  logic b_pc, b_ifw, b_idw, b_exw, b_wbw, b_ifc, b_idc, b_exc, b_st;
`ifdef HAZARD_STATS_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] exp;
    logic [8:0] exp0;
  } sb_t;

  sb_t sb[$];
  sb_t cur;

  hazard_control_unit #(.MEM_LATENCY(2), .REG_ADDR_W(5)) u_dut (
    .clock(clock), .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .Branch_Taken(Branch_Taken), .Mem_Access(Mem_Access),
    .PC_Write(a_pc), .IF_ID_Write(a_ifw), .ID_EX_Write(a_idw),
    .EX_MEM_Write(a_exw), .MEM_WB_Write(a_wbw),
    .IF_ID_clear(a_ifc), .ID_EX_clear(a_idc), .EX_MEM_clear(a_exc),
    .Stall(a_st)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(a_stall_cnt), .Flush_Count(a_flush_cnt)
`endif
  );

  hazard_control_unit #(.MEM_LATENCY(0), .REG_ADDR_W(5)) u_dut_lat0 (
    .clock(clock), .reset(reset),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .Branch_Taken(Branch_Taken), .Mem_Access(Mem_Access),
    .PC_Write(b_pc), .IF_ID_Write(b_ifw), .ID_EX_Write(b_idw),
    .EX_MEM_Write(b_exw), .MEM_WB_Write(b_wbw),
    .IF_ID_clear(b_ifc), .ID_EX_clear(b_idc), .EX_MEM_clear(b_exc),
    .Stall(b_st)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(b_stall_cnt), .Flush_Count(b_flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] vec_a();
    return {a_pc, a_ifw, a_idw, a_exw, a_wbw, a_ifc, a_idc, a_exc, a_st};
  endfunction

  function automatic logic [8:0] vec_b();
    return {b_pc, b_ifw, b_idw, b_exw, b_wbw, b_ifc, b_idc, b_exc, b_st};
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue what each instance should show.
  task automatic step(input string tag, input logic rst, input logic mr, input logic [4:0] ex_rt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br, input logic ma,
                      input logic [8:0] exp, input logic [8:0] exp0);
    sb_t e;
    @(posedge clock);
    #1;
    reset         = rst;
    ID_EX_MemRead = mr;
    ID_EX_Rt      = ex_rt;
    IF_ID_Rs      = rs;
    IF_ID_Rt      = rt;
    Branch_Taken  = br;
    Mem_Access    = ma;
    e.tag  = tag;
    e.exp  = exp;
    e.exp0 = exp0;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check({cur.tag, "_lat2"}, {23'd0, vec_a()}, {23'd0, cur.exp});
      check({cur.tag, "_lat0"}, {23'd0, vec_b()}, {23'd0, cur.exp0});
    end
  end

  initial begin
    reset = 1'b1;
    ID_EX_MemRead = 1'b0; ID_EX_Rt = '0; IF_ID_Rs = '0; IF_ID_Rt = '0;
    Branch_Taken = 1'b0; Mem_Access = 1'b0;

    //    tag           rst mr  ex_rt  rs     rt     br  ma   lat2     lat0
    step("reset_hold",  1, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_RESET, V_RESET);
    step("reset_rel",   0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("lu_rs",       0, 1, 5'd8,  5'd8,  5'd0,  0, 0, V_LU,    V_LU);
    step("lu_done",     0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("lu_zero",     0, 1, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("lu_rt",       0, 1, 5'd12, 5'd3,  5'd12, 0, 0, V_LU,    V_LU);
    step("lu_miss",     0, 1, 5'd12, 5'd3,  5'd4,  0, 0, V_IDLE,  V_IDLE);
    step("lu_noload",   0, 0, 5'd12, 5'd12, 5'd12, 0, 0, V_IDLE,  V_IDLE);
    step("flush",       0, 0, 5'd0,  5'd0,  5'd0,  1, 0, V_FLUSH, V_FLUSH);
    step("flush_done",  0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("frz_c1",      0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_FRZ,   V_IDLE);
    step("frz_c2",      0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_FRZ,   V_IDLE);
    step("frz_served",  0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_IDLE,  V_IDLE);
    step("idle_a",      0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("prio_all",    0, 1, 5'd8,  5'd8,  5'd0,  1, 1, V_FLUSH, V_FLUSH);
    step("frz_lu_c1",   0, 1, 5'd8,  5'd8,  5'd0,  0, 1, V_FRZ,   V_LU);
    step("frz_lu_c2",   0, 1, 5'd8,  5'd8,  5'd0,  0, 1, V_FRZ,   V_LU);
    step("frz_lu_after",0, 1, 5'd8,  5'd8,  5'd0,  0, 1, V_LU,    V_LU);
    step("idle_b",      0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("wait_br_c1",  0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_FRZ,   V_IDLE);
    step("wait_br_c2",  0, 0, 5'd0,  5'd0,  5'd0,  1, 1, V_FRZ,   V_FLUSH);
    step("wait_br_done",0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("mid_frz_c1",  0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_FRZ,   V_IDLE);

    // Second freeze cycle: DUT sits in MEM_WAIT, then reset lands mid-cycle.
    @(posedge clock);
    #1;
    check("mid_frz_wait_lat2", {23'd0, vec_a()}, {23'd0, V_FRZ});
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_lat2", {23'd0, vec_a()}, {23'd0, V_RESET});
    check("async_rst_lat0", {23'd0, vec_b()}, {23'd0, V_RESET});
`ifdef HAZARD_STATS_EN
    check("async_rst_stall_cnt", a_stall_cnt, 32'd0);
    check("async_rst_flush_cnt", a_flush_cnt, 32'd0);
`endif

    step("post_rst",    0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("s_lu1",       0, 1, 5'd9,  5'd9,  5'd1,  0, 0, V_LU,    V_LU);
    step("s_idle1",     0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("s_lu2",       0, 1, 5'd31, 5'd2,  5'd31, 0, 0, V_LU,    V_LU);
    step("s_idle2",     0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("s_lu3",       0, 1, 5'd1,  5'd1,  5'd1,  0, 0, V_LU,    V_LU);
    step("s_idle3",     0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);
    step("s_frz1",      0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_FRZ,   V_IDLE);
    step("s_frz2",      0, 0, 5'd0,  5'd0,  5'd0,  0, 1, V_FRZ,   V_IDLE);
    step("s_end",       0, 0, 5'd0,  5'd0,  5'd0,  0, 0, V_IDLE,  V_IDLE);

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clock);
    end
    check("sb_drain", sb.size(), 32'd0);

    @(posedge clock);
    #1;
`ifdef HAZARD_STATS_EN
    check("stall_cnt_lat2", a_stall_cnt, 32'd5);
    check("flush_cnt_lat2", a_flush_cnt, 32'd0);
    check("stall_cnt_lat0", b_stall_cnt, 32'd3);
    check("flush_cnt_lat0", b_flush_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
